// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with register-source forwarding from EX/MEM and MEM/WB,
// ALU operand selection and load-use hazard detection.
module id_ex_stage #(
  parameter int DWIDTH     = 32,
  parameter int ALU_FN_LEN = 4,
  parameter int RADDR      = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [DWIDTH-1:0]     id_pc,
  input  logic [DWIDTH-1:0]     id_rs1_data,
  input  logic [DWIDTH-1:0]     id_rs2_data,
  input  logic [DWIDTH-1:0]     id_imm,
  input  logic [RADDR-1:0]      id_rs1_addr,
  input  logic [RADDR-1:0]      id_rs2_addr,
  input  logic [RADDR-1:0]      id_rd_addr,
  input  logic [ALU_FN_LEN-1:0] id_alu_fn,
  input  logic                  id_op1_sel,
  input  logic                  id_op2_sel,
  input  logic                  id_wb_en,
  input  logic                  id_is_load,
  input  logic                  exmem_wb_en,
  input  logic                  exmem_is_load,
  input  logic [RADDR-1:0]      exmem_rd_addr,
  input  logic [DWIDTH-1:0]     exmem_data,
  input  logic                  memwb_wb_en,
  input  logic [RADDR-1:0]      memwb_rd_addr,
  input  logic [DWIDTH-1:0]     memwb_data,
  output logic                  ex_valid,
  output logic [DWIDTH-1:0]     ex_oper1,
  output logic [DWIDTH-1:0]     ex_oper2,
  output logic [ALU_FN_LEN-1:0] ex_alu_fn,
  output logic [DWIDTH-1:0]     ex_store_data,
  output logic [RADDR-1:0]      ex_rd_addr,
  output logic                  ex_wb_en,
  output logic                  ex_is_load,
  output logic                  load_use_hazard
);

  logic                  r_valid;
  logic [DWIDTH-1:0]     r_pc;
  logic [DWIDTH-1:0]     r_rs1_data;
  logic [DWIDTH-1:0]     r_rs2_data;
  logic [DWIDTH-1:0]     r_imm;
  logic [RADDR-1:0]      r_rs1_addr;
  logic [RADDR-1:0]      r_rs2_addr;
  logic [RADDR-1:0]      r_rd_addr;
  logic [ALU_FN_LEN-1:0] r_alu_fn;
  logic                  r_op1_sel;
  logic                  r_op2_sel;
  logic                  r_wb_en;
  logic                  r_is_load;

  logic [DWIDTH-1:0]     w_fwd_rs1;
  logic [DWIDTH-1:0]     w_fwd_rs2;
  logic                  w_exmem_hit_rs1;
  logic                  w_exmem_hit_rs2;
  logic                  w_memwb_hit_rs1;
  logic                  w_memwb_hit_rs2;
  logic                  w_load_in_mem;

  // Pipeline register: reset > flush > stall (with operand refresh) > load
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
      r_alu_fn   <= '0;
      r_op1_sel  <= 1'b0;
      r_op2_sel  <= 1'b0;
      r_wb_en    <= 1'b0;
      r_is_load  <= 1'b0;
    end else if (flush) begin
      r_valid    <= 1'b0;
      r_wb_en    <= 1'b0;
      r_is_load  <= 1'b0;
    end else if (stall) begin
      // A producer may retire while we wait; keep its value rather than the stale read.
      r_rs1_data <= w_fwd_rs1;
      r_rs2_data <= w_fwd_rs2;
    end else begin
      r_valid    <= id_valid;
      r_pc       <= id_pc;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_rs1_addr <= id_rs1_addr;
      r_rs2_addr <= id_rs2_addr;
      r_rd_addr  <= id_rd_addr;
      r_alu_fn   <= id_alu_fn;
      r_op1_sel  <= id_op1_sel;
      r_op2_sel  <= id_op2_sel;
      r_wb_en    <= id_wb_en;
      r_is_load  <= id_is_load;
    end
  end

  // Forwarding match detection; a load in MEM has no data yet, and x0 is never forwarded
  always_comb begin
    w_exmem_hit_rs1 = exmem_wb_en && !exmem_is_load &&
                      (exmem_rd_addr == r_rs1_addr) && (r_rs1_addr != '0);
    w_exmem_hit_rs2 = exmem_wb_en && !exmem_is_load &&
                      (exmem_rd_addr == r_rs2_addr) && (r_rs2_addr != '0);
    w_memwb_hit_rs1 = memwb_wb_en && (memwb_rd_addr == r_rs1_addr) && (r_rs1_addr != '0);
    w_memwb_hit_rs2 = memwb_wb_en && (memwb_rd_addr == r_rs2_addr) && (r_rs2_addr != '0);
    w_load_in_mem   = exmem_is_load && exmem_wb_en && (exmem_rd_addr != '0);
  end

  // Forwarded source values, youngest producer first
  always_comb begin
    w_fwd_rs1 = r_rs1_data;
    w_fwd_rs2 = r_rs2_data;
    if (w_exmem_hit_rs1) begin
      w_fwd_rs1 = exmem_data;
    end else if (w_memwb_hit_rs1) begin
      w_fwd_rs1 = memwb_data;
    end else begin
      w_fwd_rs1 = r_rs1_data;
    end
    if (w_exmem_hit_rs2) begin
      w_fwd_rs2 = exmem_data;
    end else if (w_memwb_hit_rs2) begin
      w_fwd_rs2 = memwb_data;
    end else begin
      w_fwd_rs2 = r_rs2_data;
    end
  end

  // Operand selection and EX-slot outputs
  always_comb begin
    ex_valid        = r_valid;
    ex_oper1        = r_op1_sel ? r_pc  : w_fwd_rs1;
    ex_oper2        = r_op2_sel ? r_imm : w_fwd_rs2;
    ex_store_data   = w_fwd_rs2;
    ex_alu_fn       = r_alu_fn;
    ex_rd_addr      = r_rd_addr;
    ex_wb_en        = r_valid & r_wb_en;
    ex_is_load      = r_valid & r_is_load;
    // rs2 always counts as used since stores need it as data
    load_use_hazard = r_valid && w_load_in_mem &&
                      (((exmem_rd_addr == r_rs1_addr) && !r_op1_sel) ||
                       (exmem_rd_addr == r_rs2_addr));
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage sitting directly upstream of the ALU.
- Latches decoded instruction fields from decode and resolves register-source forwarding from EX/MEM and MEM/WB.
- Selects oper1/oper2 and drives alu_fn into the ALU.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- DWIDTH, 32, datapath width (matches `DWIDTH).
- ALU_FN_LEN, 4, ALU function code width (matches `ALU_FN_LEN).
- RADDR, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold current contents.
- flush  in  1  load a bubble.
- id_valid  in  1  decode slot holds a real instruction.
- id_pc  in  DWIDTH  instruction PC.
- id_rs1_data, id_rs2_data  in  DWIDTH each  register-file read data.
- id_imm  in  DWIDTH  sign-extended immediate.
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  RADDR each  register addresses.
- id_alu_fn  in  ALU_FN_LEN  ALU operation.
- id_op1_sel  in  1  0 = rs1, 1 = pc.
- id_op2_sel  in  1  0 = rs2, 1 = imm.
- id_wb_en  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- exmem_wb_en, exmem_is_load  in  1 each  status of the instruction in MEM.
- exmem_rd_addr  in  RADDR  destination of the instruction in MEM.
- exmem_data  in  DWIDTH  ALU result of the instruction in MEM.
- memwb_wb_en  in  1  write-back enable of the instruction in WB.
- memwb_rd_addr  in  RADDR  destination of the instruction in WB.
- memwb_data  in  DWIDTH  write-back value.
- ex_valid  out  1  EX slot valid.
- ex_oper1, ex_oper2  out  DWIDTH each  ALU operands.
- ex_alu_fn  out  ALU_FN_LEN  to the ALU.
- ex_store_data  out  DWIDTH  forwarded rs2 value.
- ex_rd_addr  out  RADDR  destination register.
- ex_wb_en  out  1  write enable, gated by ex_valid.
- ex_is_load  out  1  gated by ex_valid.
- load_use_hazard  out  1  to the hazard unit.

Behaviour:
- Registered fields: valid, pc, rs1/rs2 data, imm, rs1/rs2/rd addr, alu_fn, op1/op2 sel, wb_en, is_load.
- Reset (synchronous): all registers cleared to 0. Resulting outputs: ex_valid=0, ex_wb_en=0, ex_is_load=0, ex_alu_fn=`ALU_ADD, operands 0, load_use_hazard=0. Reset overrides stall and flush. Reset asserted mid-stall discards the held instruction.
- Per-edge priority: reset > flush > stall > load.
  - flush: valid<=0; other fields don't-care, but wb_en/is_load outputs must read 0.
  - stall: hold all fields, except the data refresh described below.
  - load (neither flush nor stall): capture all id_* fields; valid<=id_valid.
- Forwarding is combinational from registered addresses, evaluated separately for rs1 and rs2:
  - Source is EX/MEM if exmem_wb_en && exmem_rd_addr==rsN && rsN!=0 && !exmem_is_load.
  - Else MEM/WB if memwb_wb_en && memwb_rd_addr==rsN && rsN!=0.
  - Else the registered data.
  - x0 is never forwarded.
- Stall refresh: while stalled, each held rsN data register is overwritten with its forwarded value every cycle. This prevents loss of a producer that retires during the stall.
- ex_oper1 = op1_sel ? pc : fwd_rs1.
- ex_oper2 = op2_sel ? imm : fwd_rs2.
- ex_store_data = fwd_rs2.
- load_use_hazard is asserted when all of the following hold: ex_valid; exmem_is_load && exmem_wb_en; exmem_rd_addr!=0; exmem_rd_addr matches a used source (rs1 when op1_sel=0; rs2 always, for store data). While asserted, the hazard unit stalls this stage and bubbles MEM, and operand outputs are don't-care.
- Latency: inputs visible at the outputs one cycle after a load edge. Forwarding paths add zero cycles.
- Simultaneous stall+flush: flush wins.
- Stall with id_valid=1: the id fields are ignored; decode must hold them.

Test Plan:
- Reset with stall=1, flush=1 -> ex_valid=0, ex_wb_en=0, ex_alu_fn=`ALU_ADD next cycle.
- Load rs1=5 (data 0x10), op2_sel=1, imm=0x4; exmem_wb_en=1, exmem_rd=5, exmem_data=0x99 -> ex_oper1=0x99, ex_oper2=0x4. With exmem_rd=0 and rs1=0 -> ex_oper1 is the register value (no forwarding).
- rs2=7 matched by both exmem (0xAA) and memwb (0xBB) -> ex_oper2=0xAA. Drop the exmem match -> 0xBB.
- Stall for 3 cycles; memwb forwards rs1=3 with 0x55 in cycle 1 only -> ex_oper1 stays 0x55 in cycles 2-3 and after release.
- exmem_is_load=1, exmem_rd=8, EX instruction rs1=8 -> load_use_hazard=1. Same case with op1_sel=1 and rs2≠8 -> 0.
- stall=1 and flush=1 together with valid contents -> ex_valid=0, ex_wb_en=0 next cycle; then an unstalled load with id_valid=1 -> ex_valid=1.
